// File: rtl/hamming_decode.sv
// rtl/hamming_decode.sv - two-stage Hamming single-error-correcting decoder
//
// Purpose: recovers a data_width payload from an encoding_width Hamming
// codeword. Bit index b of the codeword holds Hamming position b+1. The
// power-of-two positions carry parity, and the payload fills the other
// positions LSB first.
//   Stage 1 registers the syndrome and the payload positions of the word.
//   Stage 2 corrects the payload, classifies the error and registers the outputs.
// Optional feature macro: HAMMING_DECODE_ERR_CNT_EN adds a saturating error
// counter (ports clr_count, err_count).
//
// Ports:
//   clk               in   single clock, rising edge
//   rstb              in   synchronous active-high reset
//   encoded_data      in   codeword from the upstream encoder
//   valid_in          in   encoded_data qualifier, no backpressure
//   clr_count         in   (macro only) synchronous clear of err_count
//   err_count         out  (macro only) count of errored output words, saturating
//   raw_data          out  corrected payload
//   valid_out         out  qualifier for raw_data, syndrome and flags
//   syndrome          out  syndrome of the output word
//   err_corrected     out  single-bit error found and corrected
//   err_uncorrectable out  syndrome points outside the codeword
module hamming_decode #(
  parameter int data_width     = 16,
  parameter int encoding_width = 21
) (
  input  logic                                 clk,
  input  logic                                 rstb,
  input  logic [encoding_width-1:0]            encoded_data,
  input  logic                                 valid_in,
`ifdef HAMMING_DECODE_ERR_CNT_EN
  input  logic                                 clr_count,
  output logic [15:0]                          err_count,
`endif
  output logic [data_width-1:0]                raw_data,
  output logic                                 valid_out,
  output logic [encoding_width-data_width-1:0] syndrome,
  output logic                                 err_corrected,
  output logic                                 err_uncorrectable
);

  localparam int p_w = encoding_width - data_width;

  // This function gives the Hamming position (1-based) that carries payload bit j.
  // Payload bits skip every power-of-two position.
  function automatic int data_pos(input int j);
    int k;
    k = 0;
    for (int p = 1; p <= encoding_width; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (k == j) return p;
        k++;
      end
    end
    return 0;
  endfunction

  logic [p_w-1:0]        syn_in;
  logic [data_width-1:0] payload_in;
  logic [p_w-1:0]        syn1;
  logic [data_width-1:0] payload1;
  logic                  valid1;
  logic [data_width-1:0] payload_fix;
  logic                  corr_c;
  logic                  unc_c;

  // Syndrome bit i is the parity of every position whose index has bit i set.
  for (genvar i = 0; i < p_w; i++) begin : g_syn
    logic [encoding_width-1:0] term;
    for (genvar b = 0; b < encoding_width; b++) begin : g_bit
      if ((((b + 1) >> i) & 1) == 1) begin : g_on
        assign term[b] = encoded_data[b];
      end else begin : g_off
        assign term[b] = 1'b0;
      end
    end
    assign syn_in[i] = ^term;
  end

  // Parity positions are consumed by the syndrome. Only payload positions
  // go on to stage 2. A flip at a parity position therefore leaves the
  // payload unchanged.
  for (genvar j = 0; j < data_width; j++) begin : g_data
    localparam int pos = data_pos(j);
    assign payload_in[j]  = encoded_data[pos-1];
    assign payload_fix[j] = payload1[j] ^ (syn1 == p_w'(pos));
  end

  assign corr_c = (syn1 != '0) && (int'(syn1) <= encoding_width);
  assign unc_c  = (syn1 != '0) && !corr_c;

  always_ff @(posedge clk) begin
    if (rstb) begin
      valid1   <= 1'b0;
      syn1     <= '0;
      payload1 <= '0;
    end else begin
      valid1 <= valid_in;
      if (valid_in) begin
        syn1     <= syn_in;
        payload1 <= payload_in;
      end
    end
  end

  // The flags follow valid_out. raw_data and syndrome keep the last valid word.
  always_ff @(posedge clk) begin
    if (rstb) begin
      valid_out         <= 1'b0;
      raw_data          <= '0;
      syndrome          <= '0;
      err_corrected     <= 1'b0;
      err_uncorrectable <= 1'b0;
    end else begin
      valid_out <= valid1;
      if (valid1) begin
        raw_data          <= payload_fix;
        syndrome          <= syn1;
        err_corrected     <= corr_c;
        err_uncorrectable <= unc_c;
      end else begin
        err_corrected     <= 1'b0;
        err_uncorrectable <= 1'b0;
      end
    end
  end

`ifdef HAMMING_DECODE_ERR_CNT_EN
  // The counter advances on the edge that ends an errored output cycle.
  // Clear takes priority over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rstb || clr_count) begin
      err_count <= '0;
    end else if (valid_out && (err_corrected || err_uncorrectable) &&
                 (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule
